datamemory_sized: RTL
=====================

# datamemory_sized

Parametrised single-port data memory for the single-cycle/pipelined CPU datapath: byte-addressed, little-endian, with byte/half/word(/double) loads and stores, sign or zero extension on loads, and a configurable read-pipeline depth. It replaces the word-only data memory behind the execute stage. Every accepted request returns an in-order response with a fault flag for misaligned, out-of-range or unsupported accesses.

## Interface
- `width`, 32, data word width in bits; must be 32 or 64.
- `depth`, 1024, number of words; must be a power of two.
- `READ_LATENCY`, 1, cycles from request to response; legal range 1..4.
- `clk` input 1, single clock; all state changes on its rising edge.
- `reset` input 1, synchronous, active-high.
- `req_valid` input 1, request present this cycle; one request per cycle max, no backpressure.
- `req_write` input 1, 1 = store, 0 = load.
- `req_size` input 2, access size: 00 byte, 01 half, 10 word, 11 double (legal only when width=64).
- `req_unsigned` input 1, load extension: 1 = zero-extend, 0 = sign-extend; ignored for stores.
- `address` input width, byte address.
- `dataIn` input width, store data, right-aligned (bits [8·N−1:0] used for N-byte access).
- `resp_valid` output 1, one-cycle pulse per accepted request.
- `dataOut` output width, load result, right-aligned and extended; 0 for stores and faults.
- `fault` output 1, valid with `resp_valid`; 1 = request rejected.

## Operation
- Word index = `address[log2(width/8) +: log2(depth)]`; byte offset = low `log2(width/8)` bits. Byte at offset 0 = bits [7:0].
- Fault when any of: offset not a multiple of access size; address ≥ depth·width/8; `req_size`=11 with width=32.
- Faulting store: no memory write. Faulting load: `dataOut`=0, `fault`=1.
- Store: read-modify-write by byte enables; only the addressed N bytes of the word change, written at the edge ending the request cycle.
- Load: selected bytes shifted to bit 0, bits above 8·N filled with zero (`req_unsigned`=1) or copy of bit 8·N−1. Word load with width=32 ignores `req_unsigned`.
- Memory contents are not reset; only pipeline state and outputs.

## Timing
- Request sampled at edge E; response (`resp_valid`, `dataOut`, `fault`) visible after edge E+READ_LATENCY−1, i.e. READ_LATENCY cycles later; one response per request, strictly in order.
- Back-to-back requests every cycle sustain one response per cycle.
- Load in cycle T+1 to a word stored in cycle T returns the new data (write lands at end of T).
- Reset: while `reset`=1, `resp_valid`=0, `dataOut`=0, `fault`=0; requests in that cycle are dropped (no write, no response); all in-flight responses discarded. First request accepted in the cycle after `reset` falls.
- `req_valid`=0 cycles produce `resp_valid`=0 bubbles at the matching slot; `dataOut` holds 0 when `resp_valid`=0.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: misalignment faults as above.
- Undefined: offset bits below access size are forced to zero (access is silently aligned down); out-of-range and unsupported-size faults remain.

## Structure
- Package `dmem_pkg`: size encodings (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`, `SIZE_DOUBLE`), helper function for size-to-byte-mask.
- Sub-module `dmem_load_align`: combinational byte selection and sign/zero extension from word + offset + size + unsigned; also used by the store path for byte-enable generation.
- Top holds storage array, RMW write, and the READ_LATENCY-deep valid/data/fault shift pipeline.

## Test plan
- Reset 2 cycles with `req_valid`=1 store to 0x0 → no responses, `dataOut`=0, `fault`=0; later load of 0x0 shows old contents unchanged.
- sw 0xDEADBEEF @0x10, then lw @0x10 → after READ_LATENCY, `dataOut`=0xDEADBEEF, `fault`=0.
- lb @0x13 → 0xFFFFFFDE; lbu @0x13 → 0x000000DE; lh @0x12 → 0xFFFFDEAD; lhu @0x10 → 0x0000BEEF.
- sb 0x55 @0x11 then lw @0x10 → 0xDEAD55EF; sh 0x1234 @0x12 then lw → 0x123455EF.
- With macro: lw @0x12 → `fault`=1, `dataOut`=0; sw @0x0E → no change at 0x0C. Without macro: lw @0x12 → word at 0x10. lw @0x1000 (depth 1024) → `fault`=1 either way.
- READ_LATENCY=3: loads every cycle to 0x0,0x4,0x8 → three consecutive responses in order; assert `reset` while two in flight → no further `resp_valid`.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory: access-size encodings and size helpers.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;
  localparam logic [1:0] SIZE_WORD   = 2'b10;
  localparam logic [1:0] SIZE_DOUBLE = 2'b11;

  function automatic logic [7:0] size_to_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      SIZE_BYTE: mask = 8'h01;
      SIZE_HALF: mask = 8'h03;
      SIZE_WORD: mask = 8'h0F;
      default:   mask = 8'hFF;
    endcase
    return mask;
  endfunction

  function automatic int unsigned size_to_bytes(input logic [1:0] size);
    return 32'(1) << size;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Byte lane selection with sign/zero extension for loads, and byte-enable generation for stores.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned BYTES = WIDTH / 8,
  localparam int unsigned OFF_W = $clog2(BYTES)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [OFF_W-1:0] offset,
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  output logic [WIDTH-1:0] load_data_c,
  output logic [BYTES-1:0] byte_en_c
);

  logic [WIDTH-1:0] shifted;
  logic             sign_bit;
  int unsigned      nbits;

  always_comb begin
    shifted  = word >> {offset, 3'b000};
    nbits    = 8 * size_to_bytes(size);
    sign_bit = 1'b0;
    case (size)
      SIZE_BYTE: sign_bit = shifted[7];
      SIZE_HALF: sign_bit = shifted[15];
      SIZE_WORD: sign_bit = shifted[31];
      default:   sign_bit = shifted[WIDTH-1];
    endcase
    // Bits above the access width are filled; a full-width access has none to fill.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      load_data_c[i] = (i < nbits) ? shifted[i] : (~is_unsigned & sign_bit);
    end
    byte_en_c = BYTES'(size_to_mask(size)) << offset;
  end

endmodule

// File: rtl/datamemory_sized.sv
// Byte-addressed little-endian data memory with sized loads/stores and READ_LATENCY-deep response pipe.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned accesses; otherwise they are aligned down silently.
module datamemory_sized
  import dmem_pkg::*;
#(
  parameter int unsigned width        = 32,
  parameter int unsigned depth        = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [width-1:0] address,
  input  logic [width-1:0] dataIn,
  output logic             resp_valid,
  output logic [width-1:0] dataOut,
  output logic             fault
);

  localparam int unsigned BYTES = width / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(depth);
  localparam int unsigned LAT   = READ_LATENCY;

  logic [width-1:0] mem_q [depth];

  logic [OFF_W-1:0] offset_raw, offset_eff, align_mask;
  logic [IDX_W-1:0] idx;
  logic             misaligned, range_fault, size_fault, req_fault;
  logic             accept, wr_en;
  logic [width-1:0] rd_word, wr_src, wr_word_d, load_data_c;
  logic [BYTES-1:0] byte_en_c;

  logic [LAT-1:0]   vld_q, vld_d, flt_q, flt_d;
  logic [width-1:0] dat_q [LAT];
  logic [width-1:0] dat_d [LAT];

  // Request decode: word index, effective byte offset and fault causes.
  always_comb begin
    offset_raw  = address[OFF_W-1:0];
    idx         = address[OFF_W +: IDX_W];
    align_mask  = OFF_W'(size_to_bytes(req_size) - 1);
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned  = |(offset_raw & align_mask);
    offset_eff  = offset_raw;
`else
    misaligned  = 1'b0;
    offset_eff  = offset_raw & ~align_mask;
`endif
    range_fault = (address >> (OFF_W + IDX_W)) != '0;
    size_fault  = (req_size == SIZE_DOUBLE) && (width == 32);
    req_fault   = misaligned | range_fault | size_fault;
    accept      = req_valid & ~reset;
    wr_en       = accept & req_write & ~req_fault;
    rd_word     = mem_q[idx];
  end

  dmem_load_align #(.WIDTH(width)) u_align (
    .word        (rd_word),
    .offset      (offset_eff),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .load_data_c (load_data_c),
    .byte_en_c   (byte_en_c)
  );

  // Read-modify-write merge of the enabled byte lanes.
  always_comb begin
    wr_src = dataIn << {offset_eff, 3'b000};
    for (int unsigned b = 0; b < BYTES; b++) begin
      wr_word_d[b*8 +: 8] = byte_en_c[b] ? wr_src[b*8 +: 8] : rd_word[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= wr_word_d;
  end

  // Response pipe: stage 0 captures this cycle's result, later stages shift toward the output.
  always_comb begin
    vld_d    = '0;
    flt_d    = '0;
    vld_d[0] = accept;
    flt_d[0] = accept & req_fault;
    dat_d[0] = (accept & ~req_write & ~req_fault) ? load_data_c : '0;
    for (int unsigned i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      flt_d[i] = flt_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      flt_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      flt_q <= flt_d;
      for (int unsigned i = 0; i < LAT; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign resp_valid = vld_q[LAT-1];
  assign fault      = flt_q[LAT-1];
  assign dataOut    = dat_q[LAT-1];

endmodule
